// File: rtl/shares_unmask_collect_pkg.sv
// Shared types and helpers for the share-unmasking lane collector.
package shares_unmask_collect_pkg;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StDrain   = 2'd1,
    StOut     = 2'd2
  } state_e;

  // Lane counter width; a single-lane block still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned nlanes);
    return (nlanes > 1) ? $clog2(nlanes) : 1;
  endfunction

  function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/share_recombine.sv
// XOR of d registered shares back into one unmasked W-bit word.
module share_recombine
  import shares_unmask_collect_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned W = 32
) (
  input  logic [d*W-1:0] shares_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < d; i++) begin
      data_o = data_o ^ shares_i[share_lsb(i, W) +: W];
    end
  end

endmodule

// File: rtl/shares_unmask_collect.sv
// Collects NLANES masked lane words, registers the shares, unmasks them and
// presents the assembled block on a valid/ready output.
module shares_unmask_collect
  import shares_unmask_collect_pkg::*;
#(
  parameter int unsigned d      = 2,
  parameter int unsigned W      = 32,
  parameter int unsigned NLANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [d*W-1:0]        in_shares_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NLANES*W-1:0]   out_data_o,
  output logic                  busy_o
);

  localparam int unsigned     CntW    = cnt_width(NLANES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NLANES - 1);

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CntW-1:0]          idx_q, idx_d;
  logic [d*W-1:0]           share_q, share_d;
  logic                     pend_q, pend_d;
  logic [NLANES-1:0][W-1:0] lanes_q, lanes_d;
  logic [W-1:0]             lane_word;

  // Only the share register feeds the XOR, so shares never meet in unregistered logic.
  share_recombine #(
    .d(d),
    .W(W)
  ) u_recombine (
    .shares_i(share_q),
    .data_o  (lane_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    share_d    = share_q;
    pend_d     = 1'b0;
    lanes_d    = lanes_q;
    in_ready_o = 1'b0;

    if (pend_q) begin
      for (int unsigned k = 0; k < NLANES; k++) begin
        if (idx_q == CntW'(k)) begin
          lanes_d[k] = lane_word;
        end
      end
    end

    unique case (state_q)
      StCollect: begin
        in_ready_o = rst_n;
        if (in_valid_i && rst_n) begin
          share_d = in_shares_i;
          pend_d  = 1'b1;
          idx_d   = cnt_q;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // The final lane lands on this edge; the block is complete afterwards.
        if (pend_q) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          lanes_d = '0;
          state_d = StCollect;
        end
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      idx_q   <= '0;
      share_q <= '0;
      pend_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      share_q <= share_d;
      pend_q  <= pend_d;
      lanes_q <= lanes_d;
    end
  end

  assign out_valid_o = (state_q == StOut);
  assign out_data_o  = out_valid_o ? lanes_q : '0;
  assign busy_o      = !((state_q == StCollect) && (cnt_q == '0));

endmodule
